// File: rtl/da_cache_pkg.sv
// Shared widths, constants and read-FSM encoding for the DAC playback cache.
package da_cache_pkg;

  localparam int DA_DATA_NBIT     = 16;
  localparam int USB_DATA_NBIT    = 8;
  localparam int DA_CHE_ADDR_NBIT = 9;
  localparam int DA_WORD_NBIT     = 24;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    PLAY      = 2'd2,
    UNDERRUN  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/da_pingpang_ram.sv
// Simple dual-port word RAM holding both ping-pong banks; bank select is the address MSB.
module da_pingpang_ram #(
  parameter int DW = 24,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: storage is deliberately left unreset so it maps onto block RAM; bank-valid bits guard every read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/da_cache.sv
// DAC playback cache: packs host bytes into 24-bit words, stores them ping-pong, plays on sync.
// Build option: define DA_HOLD_LAST_EN to repeat the last played sample during underrun (default plays 0).
module da_cache
  import da_cache_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     sync,
  input  logic                     i_wr,
  input  logic [USB_DATA_NBIT-1:0] i_wdata,
  output logic                     o_wready,
  input  logic                     i_dac_req,
  output logic                     o_dac_strobe,
  output logic [DA_DATA_NBIT-1:0]  o_dac_data,
  output logic                     o_switch,
  output logic                     o_underrun,
  output logic                     o_drop
);

  localparam int AW = DA_CHE_ADDR_NBIT;
  localparam logic [AW-1:0] ADDR_LAST = '1;

  rd_state_e               state;
  logic [1:0]              valid, valid_nxt, valid_set, valid_clr;
  logic                    wbank, wbank_nxt, rbank, rbank_nxt;
  logic [1:0]              byte_cnt;
  logic [DA_WORD_NBIT-1:0] pack;
  logic                    wr_pend;
  logic [AW-1:0]           waddr, raddr;
  logic                    sync_d;
  logic                    pipe_vld, pipe_und;
  logic [DA_WORD_NBIT-1:0] ram_rdata;
  logic [DA_DATA_NBIT-1:0] under_val;
  logic                    wr_accept, word_done, fill_last, wbank_done;
  logic                    rd_issue, rbank_done, sync_rise, wready_nxt;

  // NOTE: every always_comb output gets a default first so no path can leave a latch behind.
  always_comb begin
    wr_accept  = i_wr & o_wready;
    word_done  = wr_accept & (byte_cnt == 2'd2);
    fill_last  = word_done & (waddr == ADDR_LAST);
    wbank_done = wr_pend & (waddr == ADDR_LAST);
    rd_issue   = (state == PLAY) & i_dac_req;
    rbank_done = rd_issue & (raddr == ADDR_LAST);
    sync_rise  = sync & ~sync_d;
    valid_set  = 2'b00;
    valid_clr  = 2'b00;
    if (wbank_done) valid_set[wbank] = HIGH;
    if (rbank_done) valid_clr[rbank] = HIGH;
    valid_nxt  = (valid | valid_set) & ~valid_clr;
    wbank_nxt  = wbank ^ wbank_done;
    rbank_nxt  = rbank ^ rbank_done;
    // Look ahead to the next bank as soon as its last word is packed, so no byte slips in before the flip.
    wready_nxt = fill_last ? ~valid_nxt[~wbank] : ~valid_nxt[wbank_nxt];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      byte_cnt <= 2'd0;
      pack     <= '0;
      wr_pend  <= LOW;
      waddr    <= '0;
      wbank    <= LOW;
      valid    <= 2'b00;
      o_wready <= LOW;
      o_drop   <= LOW;
    end else begin
      valid    <= valid_nxt;
      wbank    <= wbank_nxt;
      o_wready <= wready_nxt;
      wr_pend  <= word_done;
      if (wr_accept) begin
        pack     <= {pack[DA_WORD_NBIT-USB_DATA_NBIT-1:0], i_wdata};
        byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
      end
      if (wr_pend) waddr <= waddr + AW'(1);
      if (i_wr && !o_wready) o_drop <= HIGH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state        <= IDLE;
      sync_d       <= LOW;
      raddr        <= '0;
      rbank        <= LOW;
      o_switch     <= LOW;
      pipe_vld     <= LOW;
      pipe_und     <= LOW;
      o_dac_strobe <= LOW;
      o_dac_data   <= '0;
      o_underrun   <= LOW;
    end else begin
      sync_d   <= sync;
      rbank    <= rbank_nxt;
      o_switch <= rbank_nxt;
      pipe_vld <= LOW;
      pipe_und <= LOW;
      case (state)
        IDLE:      state <= WAIT_SYNC;
        WAIT_SYNC: if (sync_rise && valid[rbank]) state <= PLAY;
        PLAY: begin
          if (rd_issue) begin
            pipe_vld <= HIGH;
            raddr    <= raddr + AW'(1);
            if (rbank_done && !valid[~rbank]) state <= UNDERRUN;
          end
        end
        UNDERRUN: begin
          if (i_dac_req) begin
            pipe_vld   <= HIGH;
            pipe_und   <= HIGH;
            o_underrun <= HIGH;
          end
          if (valid[rbank]) state <= PLAY;
        end
        default: state <= IDLE;
      endcase
      o_dac_strobe <= pipe_vld;
      if (pipe_vld) o_dac_data <= pipe_und ? under_val : ram_rdata[DA_DATA_NBIT-1:0];
    end
  end

`ifdef DA_HOLD_LAST_EN
  logic [DA_DATA_NBIT-1:0] last_sample;

  always_ff @(posedge clk) begin
    if (rst || !en)               last_sample <= '0;
    else if (pipe_vld && !pipe_und) last_sample <= ram_rdata[DA_DATA_NBIT-1:0];
  end

  assign under_val = last_sample;
`else
  assign under_val = '0;
`endif

  // Top byte of each word is stored but never played.
  logic [DA_WORD_NBIT-DA_DATA_NBIT-1:0] rdata_unused;
  assign rdata_unused = ram_rdata[DA_WORD_NBIT-1:DA_DATA_NBIT];

  da_pingpang_ram #(
    .DW(DA_WORD_NBIT),
    .AW(AW + 1)
  ) u_ram (
    .clk   (clk),
    .we    (wr_pend),
    .waddr ({wbank, waddr}),
    .wdata (pack),
    .re    (rd_issue),
    .raddr ({rbank, raddr}),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_da_cache.sv
// Directed-plus-random bench for da_cache against a bank-level playback model.
module tb_da_cache;
  import da_cache_pkg::*;

  localparam int W = 1 << DA_CHE_ADDR_NBIT;
`ifdef DA_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct {
    logic [DA_DATA_NBIT-1:0] data;
    int                      cyc;
  } ev_t;

  logic                     clk = 1'b0;
  logic                     rst, en, sync, i_wr, i_dac_req;
  logic [USB_DATA_NBIT-1:0] i_wdata;
  logic                     o_wready, o_dac_strobe, o_switch, o_underrun, o_drop;
  logic [DA_DATA_NBIT-1:0]  o_dac_data;

  int n_cmp = 0;
  int n_bad = 0;
  int pcyc  = 0;
  bit abort = 1'b0;

  // Reference model: accepted bytes -> words -> whole banks queued for playback.
  int                      m_cnt;
  logic [DA_WORD_NBIT-1:0] m_pack;
  logic [DA_DATA_NBIT-1:0] m_part[$];
  logic [DA_DATA_NBIT-1:0] m_play[$];
  logic [DA_DATA_NBIT-1:0] m_last;
  bit                      m_playing, m_rbank, m_under, m_drop;
  ev_t                     exp_q[$];
  ev_t                     obs_q[$];

  da_cache dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sync         (sync),
    .i_wr         (i_wr),
    .i_wdata      (i_wdata),
    .o_wready     (o_wready),
    .i_dac_req    (i_dac_req),
    .o_dac_strobe (o_dac_strobe),
    .o_dac_data   (o_dac_data),
    .o_switch     (o_switch),
    .o_underrun   (o_underrun),
    .o_drop       (o_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  always @(negedge clk)
    if (o_dac_strobe === 1'b1) obs_q.push_back(ev_t'{o_dac_data, pcyc});

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_cnt     = 0;
    m_pack    = '0;
    m_last    = '0;
    m_playing = 1'b0;
    m_rbank   = 1'b0;
    m_under   = 1'b0;
    m_drop    = 1'b0;
    m_part.delete();
    m_play.delete();
  endfunction

  function automatic void m_accept(input logic [USB_DATA_NBIT-1:0] b);
    m_pack = {m_pack[DA_WORD_NBIT-USB_DATA_NBIT-1:0], b};
    m_cnt++;
    if (m_cnt == 3) begin
      m_cnt = 0;
      m_part.push_back(m_pack[DA_DATA_NBIT-1:0]);
      if (m_part.size() == W) begin
        foreach (m_part[i]) m_play.push_back(m_part[i]);
        m_part.delete();
      end
    end
  endfunction

  function automatic int m_banks();
    return (m_play.size() + W - 1) / W;
  endfunction

  function automatic logic exp_wready();
    return m_banks() < 2;
  endfunction

  function automatic void m_req();
    logic [DA_DATA_NBIT-1:0] d;
    if (!m_playing) return;
    if (m_play.size() > 0) begin
      d      = m_play.pop_front();
      m_last = d;
      if (m_play.size() % W == 0) m_rbank = ~m_rbank;
    end else begin
      m_under = 1'b1;
      d       = HOLD ? m_last : '0;
    end
    exp_q.push_back(ev_t'{d, pcyc + 2});
  endfunction

  task automatic put_byte(input logic [USB_DATA_NBIT-1:0] b);
    int waited = 0;
    if (abort) return;
    while (o_wready !== 1'b1) begin
      i_wr = 1'b0;
      @(negedge clk);
      waited++;
      if (waited > 4000) begin
        check("wready_wait", o_wready, 1'b1);
        abort = 1'b1;
        return;
      end
    end
    i_wr    = 1'b1;
    i_wdata = b;
    m_accept(b);
    @(negedge clk);
    i_wr = 1'b0;
  endtask

  task automatic drop_byte(input logic [USB_DATA_NBIT-1:0] b);
    i_wr    = 1'b1;
    i_wdata = b;
    m_drop  = 1'b1;
    @(negedge clk);
    i_wr = 1'b0;
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      put_byte(USB_DATA_NBIT'($urandom));
      if ($urandom_range(7) == 0) @(negedge clk);
    end
  endtask

  task automatic req();
    i_dac_req = 1'b1;
    m_req();
    @(negedge clk);
    i_dac_req = 1'b0;
  endtask

  task automatic play(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      req();
      if (gaps) repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    if (!m_playing && m_banks() > 0) m_playing = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain_compare(input string tag);
    ev_t e, o;
    repeat (4) @(negedge clk);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_data"}, o.data, e.data);
      check({tag, "_cycle"}, o.cyc, e.cyc);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sync = 1'b0;
    i_wr = 1'b0; i_wdata = '0; i_dac_req = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_wready", o_wready, 1'b0);
    check("rst_strobe", o_dac_strobe, 1'b0);
    check("rst_data", o_dac_data, '0);
    check("rst_switch", o_switch, m_rbank);
    check("rst_underrun", o_underrun, m_under);
    check("rst_drop", o_drop, m_drop);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("wready_after_rst", o_wready, exp_wready());

    // Ramp fill of bank 0, then back-to-back playback.
    for (int k = 0; k < W; k++) begin
      put_byte(8'h00);
      put_byte(USB_DATA_NBIT'((k + 1) >> 8));
      put_byte(USB_DATA_NBIT'(k + 1));
    end
    repeat (3) @(negedge clk);
    check("ramp_wready", o_wready, exp_wready());
    check("ramp_switch", o_switch, m_rbank);
    pulse_sync();
    play(W, 1'b0);
    drain_compare("ramp");
    check("ramp_switch_end", o_switch, m_rbank);
    check("ramp_underrun", o_underrun, m_under);

    // Underrun with bank 1 empty, then refill and resume.
    play(3, 1'b1);
    drain_compare("under");
    check("under_flag", o_underrun, m_under);
    fill_random(3 * W);
    repeat (4) @(negedge clk);
    play(20, 1'b1);
    drain_compare("resume");

    // Both banks full: extra bytes are dropped and word alignment survives.
    fill_random(3 * W);
    repeat (3) @(negedge clk);
    check("full_wready", o_wready, exp_wready());
    for (int i = 0; i < 5; i++) drop_byte(USB_DATA_NBIT'($urandom));
    @(negedge clk);
    check("drop_flag", o_drop, m_drop);
    play(W - 20, 1'b0);
    drain_compare("free_bank");
    check("freed_wready", o_wready, exp_wready());
    fill_random(3 * W);
    repeat (4) @(negedge clk);
    play(W + 8, 1'b1);
    drain_compare("after_drop");
    check("after_drop_switch", o_switch, m_rbank);

    // en dropped with requests in flight.
    i_dac_req = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    i_dac_req = 1'b0;
    m_reset();
    check("en0_strobe", o_dac_strobe, 1'b0);
    check("en0_data", o_dac_data, '0);
    check("en0_underrun", o_underrun, m_under);
    check("en0_drop", o_drop, m_drop);
    check("en0_switch", o_switch, m_rbank);
    check("en0_wready", o_wready, 1'b0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    check("reen_wready", o_wready, exp_wready());
    drain_compare("en_flush");

    // sync with nothing valid is ignored.
    pulse_sync();
    play(3, 1'b1);
    drain_compare("nosync");
    check("nosync_underrun", o_underrun, m_under);

    // rst mid-word, then a fresh bank plays from a clean word boundary.
    put_byte(USB_DATA_NBIT'($urandom));
    put_byte(USB_DATA_NBIT'($urandom));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    fill_random(3 * W);
    repeat (4) @(negedge clk);
    check("rstfill_switch", o_switch, m_rbank);
    pulse_sync();
    play(8, 1'b1);
    pulse_sync();
    play(8, 1'b1);
    drain_compare("rst_fill");
    check("final_wready", o_wready, exp_wready());
    check("final_underrun", o_underrun, m_under);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
